fp_addsub_acc: RTL and testbench

Pipelined signed fixed-point add/subtract unit with optional running accumulation, selectable saturate or wrap, and per-result plus sticky overflow/underflow flags. It succeeds the single-mode fixed-point adder in the arithmetic datapath. It takes one operand pair per cycle with valid tagging and returns results two clock edges later, so it can run streaming sums and short accumulations in Q(W_len-W_fract).W_fract format.

---
 rtl/fp_addsub_acc_if.sv | 28 ++
 rtl/fp_addsub_acc.sv | 99 +++++++++
 tb/tb_fp_addsub_acc.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_acc_if.sv
// rtl/fp_addsub_acc_if.sv - operand/result bundle for the fixed-point add/sub accumulator
interface fp_addsub_acc_if #(
    parameter int W_len = 16
);
    logic              in_valid;
    logic              op_sub;
    logic              acc_en;
    logic              sat_en;
    logic              clear;
    logic [W_len-1:0]  a;
    logic [W_len-1:0]  b;
    logic              out_valid;
    logic [W_len-1:0]  sum;
    logic              overflow;
    logic              underflow;
    logic              ovf_sticky;
    logic              unf_sticky;

    modport master (
        output in_valid, op_sub, acc_en, sat_en, clear, a, b,
        input  out_valid, sum, overflow, underflow, ovf_sticky, unf_sticky
    );

    modport slave (
        input  in_valid, op_sub, acc_en, sat_en, clear, a, b,
        output out_valid, sum, overflow, underflow, ovf_sticky, unf_sticky
    );
endinterface

// File: rtl/fp_addsub_acc.sv
// rtl/fp_addsub_acc.sv - two-stage signed fixed-point add/sub with accumulator and saturate/wrap
module fp_addsub_acc #(
    parameter int W_len   = 16,
    parameter int W_fract = 14,
    parameter int W_out   = W_len
) (
    input  logic             clk,
    input  logic             reset,
    fp_addsub_acc_if.slave   bus
);

    // W_fract only names the Q format; the arithmetic is format-agnostic.
    if (W_fract >= W_len || W_out != W_len) begin : g_param_check
        $error("fp_addsub_acc: need W_fract < W_len and W_out == W_len");
    end

    logic [W_len-1:0] a_r, b_r;
    logic             op_sub_r, acc_en_r, sat_en_r, v1;

    logic [W_len-1:0] acc;
    logic [W_len-1:0] sum_q;
    logic             out_valid_q, overflow_q, underflow_q;
    logic             ovf_sticky_q, unf_sticky_q;

    logic signed [W_len:0] a_ext, b_ext, r;
    logic                  ovf, unf;
    logic [W_len-1:0]      res;

    // Stage 1: capture operands and controls every edge; no backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r      <= '0;
            b_r      <= '0;
            op_sub_r <= 1'b0;
            acc_en_r <= 1'b0;
            sat_en_r <= 1'b0;
            v1       <= 1'b0;
        end else begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            op_sub_r <= bus.op_sub;
            acc_en_r <= bus.acc_en;
            sat_en_r <= bus.sat_en;
            v1       <= bus.in_valid;
        end
    end

    // Exact W_len+1 result; range error shows as disagreeing top two bits.
    always_comb begin
        a_ext = acc_en_r ? $signed({acc[W_len-1], acc}) : $signed({a_r[W_len-1], a_r});
        b_ext = $signed({b_r[W_len-1], b_r});
        r     = op_sub_r ? (a_ext - b_ext) : (a_ext + b_ext);
        ovf   = ~r[W_len] &  r[W_len-1];
        unf   =  r[W_len] & ~r[W_len-1];
        res   = r[W_len-1:0];
        if (sat_en_r && ovf) begin
            res = {1'b0, {(W_len-1){1'b1}}};
        end else if (sat_en_r && unf) begin
            res = {1'b1, {(W_len-1){1'b0}}};
        end
    end

    // Stage 2: register result and flags; clear wins over accumulator/sticky updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc          <= '0;
            sum_q        <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            out_valid_q <= v1;
            overflow_q  <= v1 & ovf;
            underflow_q <= v1 & unf;
            if (v1) begin
                sum_q <= res;
            end
            if (bus.clear) begin
                acc          <= '0;
                ovf_sticky_q <= 1'b0;
                unf_sticky_q <= 1'b0;
            end else if (v1) begin
                acc          <= res;
                ovf_sticky_q <= ovf_sticky_q | ovf;
                unf_sticky_q <= unf_sticky_q | unf;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.sum        = sum_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
    assign bus.ovf_sticky = ovf_sticky_q;
    assign bus.unf_sticky = unf_sticky_q;

endmodule

// File: tb/tb_fp_addsub_acc.sv
// tb/tb_fp_addsub_acc.sv - self-checking bench for fp_addsub_acc
module tb_fp_addsub_acc;
    localparam int W = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    fp_addsub_acc_if #(.W_len(W)) bus();

    fp_addsub_acc #(.W_len(W), .W_fract(14), .W_out(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: integer arithmetic on whole values
    int          m_acc;
    logic        m_os, m_us;
    logic        e_valid, e_ovf, e_unf;
    logic [15:0] e_sum;
    logic        p_v, p_sub, p_ae, p_sat;
    logic [15:0] p_a, p_b;

    task automatic model_reset();
        m_acc = 0; m_os = 1'b0; m_us = 1'b0;
        e_valid = 1'b0; e_ovf = 1'b0; e_unf = 1'b0; e_sum = 16'h0;
        p_v = 1'b0; p_sub = 1'b0; p_ae = 1'b0; p_sat = 1'b0; p_a = 16'h0; p_b = 16'h0;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0; bus.op_sub = 1'b0; bus.acc_en = 1'b0;
        bus.sat_en = 1'b0; bus.clear = 1'b0; bus.a = '0; bus.b = '0;
    endtask

    // Present one input, advance one edge, update the model for what that edge produced.
    task automatic step(input logic v, input logic sub, input logic ae, input logic sat,
                        input logic clr, input logic [15:0] a, input logic [15:0] b);
        int ea;
        int r;
        bus.in_valid = v; bus.op_sub = sub; bus.acc_en = ae; bus.sat_en = sat;
        bus.clear = clr; bus.a = a; bus.b = b;
        @(posedge clk);
        #1;
        if (p_v) begin
            ea = p_ae ? m_acc : int'($signed(p_a));
            r  = p_sub ? (ea - int'($signed(p_b))) : (ea + int'($signed(p_b)));
            e_valid = 1'b1;
            e_ovf   = (r > 32767);
            e_unf   = (r < -32768);
            if (p_sat && e_ovf)      e_sum = 16'h7FFF;
            else if (p_sat && e_unf) e_sum = 16'h8000;
            else                     e_sum = r[15:0];
            m_acc = int'($signed(e_sum));
            m_os  = m_os | e_ovf;
            m_us  = m_us | e_unf;
        end else begin
            e_valid = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
        end
        if (clr) begin
            m_acc = 0; m_os = 1'b0; m_us = 1'b0;
        end
        p_v = v; p_sub = sub; p_ae = ae; p_sat = sat; p_a = a; p_b = b;
    endtask

    task automatic test_reset();
        logic [20:0] obs;
        idle_inputs();
        model_reset();
        reset = 1'b0;
        #12;
        obs = {bus.out_valid, bus.overflow, bus.underflow, bus.ovf_sticky, bus.unf_sticky, bus.sum};
        n_cmp++; if (obs !== 21'h0) begin n_bad++; $display("FAIL reset_init: got %h want %h", obs, 21'h0); end
        @(negedge clk) reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1000, 16'h0100);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2000, 16'h0010);
        n_cmp++; if (bus.sum !== 16'h1100 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL reset_prestream: got %h/%b want 1100/1", bus.sum, bus.out_valid); end
        idle_inputs();
        #3 reset = 1'b0;
        #1;
        obs = {bus.out_valid, bus.overflow, bus.underflow, bus.ovf_sticky, bus.unf_sticky, bus.sum};
        n_cmp++; if (obs !== 21'h0) begin n_bad++; $display("FAIL reset_async: got %h want %h", obs, 21'h0); end
        model_reset();
        #2 reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_noflight1: got %b want 0", bus.out_valid); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_noflight2: got %b want 0", bus.out_valid); end
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h7777, 16'h1234);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_lat1: got %b want 0", bus.out_valid); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.sum !== 16'h1234) begin n_bad++; $display("FAIL reset_acc_zero: got %b/%h want 1/1234", bus.out_valid, bus.sum); end
    endtask

    task automatic test_plain_add();
        logic [15:0] ra, rb;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2000, 16'h9000);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL add_early_valid: got %b want 0", bus.out_valid); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        n_cmp++; if ({bus.out_valid, bus.overflow, bus.underflow, bus.sum} !== {3'b100, 16'hB000}) begin
            n_bad++; $display("FAIL add_result: got v%b o%b u%b %h want v1 o0 u0 b000", bus.out_valid, bus.overflow, bus.underflow, bus.sum); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.sum !== 16'hB000) begin n_bad++; $display("FAIL add_hold: got %b/%h want 0/b000", bus.out_valid, bus.sum); end
        for (int i = 0; i < 5; i++) begin
            ra = 16'($urandom_range(0, 16'h3FFF)) - 16'h2000;
            rb = 16'($urandom_range(0, 16'h3FFF)) - 16'h2000;
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, ra, rb);
            n_cmp++; if (bus.out_valid !== e_valid || bus.sum !== e_sum) begin n_bad++; $display("FAIL add_stream%0d: got %b/%h want %b/%h", i, bus.out_valid, bus.sum, e_valid, e_sum); end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.sum !== e_sum) begin n_bad++; $display("FAIL add_stream_last: got %b/%h want 1/%h", bus.out_valid, bus.sum, e_sum); end
    endtask

    task automatic test_overflow();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5555, 16'h4000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5555, 16'h4000);
        n_cmp++; if ({bus.sum, bus.overflow, bus.ovf_sticky, bus.underflow} !== {16'h7FFF, 3'b110}) begin
            n_bad++; $display("FAIL ovf_sat: got %h o%b s%b u%b want 7fff o1 s1 u0", bus.sum, bus.overflow, bus.ovf_sticky, bus.underflow); end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h7777, 16'h8887);
        n_cmp++; if ({bus.sum, bus.overflow} !== {16'h9555, 1'b1}) begin n_bad++; $display("FAIL ovf_wrap: got %h o%b want 9555 o1", bus.sum, bus.overflow); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        n_cmp++; if ({bus.sum, bus.overflow} !== {16'h7FFF, 1'b1}) begin n_bad++; $display("FAIL ovf_sub: got %h o%b want 7fff o1", bus.sum, bus.overflow); end
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h9000, 16'hD000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9000, 16'hD000);
        n_cmp++; if ({bus.sum, bus.underflow, bus.unf_sticky, bus.overflow} !== {16'h8000, 3'b110}) begin
            n_bad++; $display("FAIL unf_sat: got %h u%b s%b o%b want 8000 u1 s1 o0", bus.sum, bus.underflow, bus.unf_sticky, bus.overflow); end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0100);
        n_cmp++; if ({bus.sum, bus.underflow} !== {16'h6000, 1'b1}) begin n_bad++; $display("FAIL unf_wrap: got %h u%b want 6000 u1", bus.sum, bus.underflow); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        n_cmp++; if ({bus.sum, bus.underflow, bus.unf_sticky} !== {16'h0200, 2'b01}) begin
            n_bad++; $display("FAIL unf_sticky_clean: got %h u%b s%b want 0200 u0 s1", bus.sum, bus.underflow, bus.unf_sticky); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        n_cmp++; if ({bus.out_valid, bus.unf_sticky} !== 2'b01) begin n_bad++; $display("FAIL unf_sticky_idle: got v%b s%b want v0 s1", bus.out_valid, bus.unf_sticky); end
    endtask

    task automatic test_accumulate();
        logic [15:0] want [4];
        want[0] = 16'h2000; want[1] = 16'h4000; want[2] = 16'h6000; want[3] = 16'h7FFF;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'($urandom), 16'h2000);
            else       step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            if (i > 0) begin
                n_cmp++; if ({bus.out_valid, bus.sum, bus.overflow} !== {1'b1, want[i-1], (i == 4)}) begin
                    n_bad++; $display("FAIL acc_step%0d: got v%b %h o%b want v1 %h o%b", i-1, bus.out_valid, bus.sum, bus.overflow, want[i-1], (i == 4)); end
            end
        end
    endtask

    task automatic test_clear_collision();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'($urandom), 16'h8000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        n_cmp++; if ({bus.out_valid, bus.sum, bus.overflow, bus.ovf_sticky, bus.unf_sticky} !== {1'b1, 16'h7FFF, 3'b100}) begin
            n_bad++; $display("FAIL clr_collide: got v%b %h o%b so%b su%b want v1 7fff o1 so0 su0", bus.out_valid, bus.sum, bus.overflow, bus.ovf_sticky, bus.unf_sticky); end
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h5A5A, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        n_cmp++; if ({bus.out_valid, bus.sum, bus.ovf_sticky} !== {1'b1, 16'h0000, 1'b0}) begin
            n_bad++; $display("FAIL clr_acc_zero: got v%b %h so%b want v1 0000 so0", bus.out_valid, bus.sum, bus.ovf_sticky); end
    endtask

    task automatic test_random();
        logic [4:0] obs_f, exp_f;
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 15) == 0), 16'($urandom), 16'($urandom));
            obs_f = {bus.out_valid, bus.overflow, bus.underflow, bus.ovf_sticky, bus.unf_sticky};
            exp_f = {e_valid, e_ovf, e_unf, m_os, m_us};
            n_cmp++; if (obs_f !== exp_f) begin n_bad++; $display("FAIL rand_flags%0d: got %b want %b", i, obs_f, exp_f); end
            n_cmp++; if (bus.sum !== e_sum) begin n_bad++; $display("FAIL rand_sum%0d: got %h want %h", i, bus.sum, e_sum); end
        end
    endtask

    initial begin
        test_reset();
        test_plain_add();
        test_overflow();
        test_underflow();
        test_accumulate();
        test_clear_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
